// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses the async-read instruction ROM,
// and hands (pc, instruction) pairs to decode through a one-entry valid/ready buffer.
module instruction_fetch_unit #(
  parameter int unsigned           XLEN              = 32,
  parameter logic [XLEN-1:0]       RESET_PC          = 32'h0000_0000,
  parameter int unsigned           INSTRUCTION_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fetch_enable,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic [XLEN-1:0]              imem_address,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_instruction,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction
);

  localparam int unsigned WORD_W = XLEN - 2;

  // PC kept as a word index so the byte address is aligned by construction.
  logic [WORD_W-1:0] pc_word;
  logic              load_c;
  logic              unused_redirect_lsbs;

  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  assign imem_address = {pc_word, 2'b00};

  assign load_c = fetch_enable && (!out_valid || out_ready) && !redirect_valid;

  // Redirect beats load, which beats a plain consume; otherwise everything holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_word         <= RESET_PC[XLEN-1:2];
      out_valid       <= 1'b0;
      out_pc          <= '0;
      out_instruction <= '0;
    end else if (redirect_valid) begin
      pc_word   <= redirect_pc[XLEN-1:2];
      out_valid <= 1'b0;
    end else if (load_c) begin
      pc_word         <= pc_word + WORD_W'(1);
      out_valid       <= 1'b1;
      out_pc          <= {pc_word, 2'b00};
      out_instruction <= imem_instruction;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit: two instances, one with
// RESET_PC = 0 and one with RESET_PC = 0xFFFF_FFFC for the wrap case.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, fe_a, redir_a, ready_a;
  logic [31:0] redir_pc_a, addr_a, instr_a, out_pc_a, out_instr_a;
  logic        valid_a;

  logic        rst_b, fe_b, redir_b, ready_b;
  logic [31:0] redir_pc_b, addr_b, instr_b, out_pc_b, out_instr_b;
  logic        valid_b;

  int checks = 0;
  int errors = 0;

  // ROM contents: word n holds 0x11*(n+1), so 0,4,8,C -> 11,22,33,44.
  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return 32'(32'h11 * (w + 32'd1));
  endfunction

  assign instr_a = rom(addr_a);
  assign instr_b = rom(addr_b);

  instruction_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .INSTRUCTION_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst_a), .fetch_enable(fe_a), .redirect_valid(redir_a),
    .redirect_pc(redir_pc_a), .imem_address(addr_a), .imem_instruction(instr_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_pc(out_pc_a), .out_instruction(out_instr_a)
  );

  instruction_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .INSTRUCTION_WIDTH(32)) dut_b (
    .clk(clk), .rst(rst_b), .fetch_enable(fe_b), .redirect_valid(redir_b),
    .redirect_pc(redir_pc_b), .imem_address(addr_b), .imem_instruction(instr_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_pc(out_pc_b), .out_instruction(out_instr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check full output state of instance A.
  task automatic chk_a(input string tag, input logic v, input logic [31:0] pc,
                       input logic [31:0] ins, input logic [31:0] addr);
    chk({tag, ".valid"}, 32'(valid_a), 32'(v));
    if (v) begin
      chk({tag, ".pc"}, out_pc_a, pc);
      chk({tag, ".instr"}, out_instr_a, ins);
    end
    chk({tag, ".addr"}, addr_a, addr);
  endtask

  initial begin
    rst_a = 1'b1; fe_a = 1'b1; redir_a = 1'b0; redir_pc_a = '0; ready_a = 1'b1;
    rst_b = 1'b1; fe_b = 1'b1; redir_b = 1'b0; redir_pc_b = '0; ready_b = 1'b1;
    #2;
    step();
    step();
    chk_a("reset", 1'b0, 32'h0, 32'h0, 32'h0);
    chk("reset.out_pc", out_pc_a, 32'h0);
    chk("reset.out_instr", out_instr_a, 32'h0);
    chk("reset_b.addr", addr_b, 32'hFFFF_FFFC);
    chk("reset_b.valid", 32'(valid_b), 32'h0);

    // Full-throughput stream
    rst_a = 1'b0;
    step(); chk_a("stream0", 1'b1, 32'h0, 32'h11, 32'h4);
    step(); chk_a("stream1", 1'b1, 32'h4, 32'h22, 32'h8);
    step(); chk_a("stream2", 1'b1, 32'h8, 32'h33, 32'hC);
    step(); chk_a("stream3", 1'b1, 32'hC, 32'h44, 32'h10);

    // Restart, then backpressure while out_pc = 4
    rst_a = 1'b1; step(); rst_a = 1'b0;
    chk_a("rst2", 1'b0, 32'h0, 32'h0, 32'h0);
    step(); chk_a("bp_pre0", 1'b1, 32'h0, 32'h11, 32'h4);
    step(); chk_a("bp_pre1", 1'b1, 32'h4, 32'h22, 32'h8);
    ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_a("bp_stall", 1'b1, 32'h4, 32'h22, 32'h8);
    end
    ready_a = 1'b1;
    step(); chk_a("bp_rel0", 1'b1, 32'h8, 32'h33, 32'hC);
    step(); chk_a("bp_rel1", 1'b1, 32'hC, 32'h44, 32'h10);

    // Redirect flush with out_ready high; low bits of target ignored
    redir_a = 1'b1; redir_pc_a = 32'h0000_0013;
    step(); chk_a("flush", 1'b0, 32'h0, 32'h0, 32'h10);
    redir_a = 1'b0;
    step(); chk_a("flush_tgt", 1'b1, 32'h10, 32'h55, 32'h14);

    // Stall, then back-to-back redirects 0x20 and 0x40
    ready_a = 1'b0;
    step(); chk_a("stall2", 1'b1, 32'h10, 32'h55, 32'h14);
    redir_a = 1'b1; redir_pc_a = 32'h20;
    step(); chk_a("redir20", 1'b0, 32'h0, 32'h0, 32'h20);
    redir_pc_a = 32'h40;
    step(); chk_a("redir40", 1'b0, 32'h0, 32'h0, 32'h40);
    redir_a = 1'b0; ready_a = 1'b1;
    step(); chk_a("redir_tgt", 1'b1, 32'h40, 32'h121, 32'h44);

    // fetch_enable low: pending entry consumed, pc holds, then resume
    fe_a = 1'b0;
    step(); chk_a("fe_off0", 1'b0, 32'h0, 32'h0, 32'h44);
    chk("fe_off0.out_pc_hold", out_pc_a, 32'h40);
    step(); chk_a("fe_off1", 1'b0, 32'h0, 32'h0, 32'h44);
    fe_a = 1'b1;
    step(); chk_a("fe_on", 1'b1, 32'h44, 32'h132, 32'h48);

    // Async reset between edges takes effect without a clock edge
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("async.valid", 32'(valid_a), 32'h0);
    chk("async.addr", addr_a, 32'h0);
    step(); rst_a = 1'b0;
    step(); chk_a("after_async", 1'b1, 32'h0, 32'h11, 32'h4);

    // PC wrap on instance B
    rst_b = 1'b0;
    step();
    chk("wrap0.valid", 32'(valid_b), 32'h1);
    chk("wrap0.pc", out_pc_b, 32'hFFFF_FFFC);
    chk("wrap0.instr", out_instr_b, 32'h4000_0000);
    chk("wrap0.addr", addr_b, 32'h0);
    step();
    chk("wrap1.pc", out_pc_b, 32'h0);
    chk("wrap1.instr", out_instr_b, 32'h11);
    chk("wrap1.addr", addr_b, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
